// File: rtl/nabp_image_ram_writer.sv
// rtl/nabp_image_ram_writer.sv - scales back-projected pixels, buffers them and writes them to image SRAM.
// Optional saturating narrowing is enabled by defining NABP_IMAGE_WRITER_SATURATE_EN.
module nabp_image_ram_writer #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 12,
   parameter int PIX_WIDTH  = 8,
   parameter int SHIFT      = 4,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  ir_kick,
   input  logic                  ir_done,
   input  logic                  ir_addr_valid,
   input  logic [ADDR_WIDTH-1:0] ir_addr,
   input  logic [DATA_WIDTH-1:0] ir_val,
   output logic                  ir_enable,
   output logic                  mem_wr_en,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [PIX_WIDTH-1:0]  mem_data,
   input  logic                  mem_ready,
   output logic                  frame_done,
   output logic [ADDR_WIDTH:0]   pix_count,
   output logic                  err_overflow,
   output logic                  err_protocol
);
   localparam int PTR_W   = $clog2(FIFO_DEPTH);
   localparam int ENTRY_W = ADDR_WIDTH + PIX_WIDTH;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   state_t                    state, state_next;
   logic [ENTRY_W-1:0]        fifo [FIFO_DEPTH];
   logic [PTR_W-1:0]          wr_ptr, rd_ptr;
   logic [PTR_W:0]            count, count_next;
   logic signed [DATA_WIDTH-1:0] shifted;
   logic [PIX_WIDTH-1:0]      pixel;
   logic                      accepting, full, push, pop, overflow, handshake, protocol_err;

   assign shifted = $signed(ir_val) >>> SHIFT;

`ifdef NABP_IMAGE_WRITER_SATURATE_EN
   always_comb begin
      pixel = shifted[PIX_WIDTH-1:0];
      if (shifted[DATA_WIDTH-1])
         pixel = '0;
      else if (|shifted[DATA_WIDTH-1:PIX_WIDTH])
         pixel = '1;
   end
`else
   logic unused_high_bits;
   assign unused_high_bits = ^shifted[DATA_WIDTH-1:PIX_WIDTH];
   assign pixel = shifted[PIX_WIDTH-1:0];
`endif

   always_comb begin
      accepting  = (state == S_RUN) || (state == S_DRAIN);
      full       = (count == (PTR_W+1)'(FIFO_DEPTH));
      handshake  = mem_wr_en && mem_ready;
      // The head register refills whenever it is empty or being consumed this cycle.
      pop        = (count != '0) && (!mem_wr_en || mem_ready);
      push       = accepting && ir_addr_valid && (!full || pop);
      overflow   = accepting && ir_addr_valid && full && !pop;
      count_next = count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
      protocol_err = (ir_kick && (state != S_IDLE)) ||
                     (ir_addr_valid && ((state == S_IDLE) || (state == S_DONE)));
      state_next = state;
      case (state)
         S_IDLE:  if (ir_kick) state_next = S_RUN;
         S_RUN:   if (ir_done) state_next = S_DRAIN;
         S_DRAIN: if ((count == '0) && !mem_wr_en && !push) state_next = S_DONE;
         S_DONE:  state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state        <= S_IDLE;
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         ir_enable    <= 1'b0;
         mem_wr_en    <= 1'b0;
         mem_addr     <= '0;
         mem_data     <= '0;
         frame_done   <= 1'b0;
         pix_count    <= '0;
         err_overflow <= 1'b0;
         err_protocol <= 1'b0;
      end else begin
         state <= state_next;
         count <= count_next;
         if (push) begin
            fifo[wr_ptr] <= {ir_addr, pixel};
            wr_ptr       <= wr_ptr + 1'b1;
         end
         if (pop) begin
            {mem_addr, mem_data} <= fifo[rd_ptr];
            rd_ptr               <= rd_ptr + 1'b1;
            mem_wr_en            <= 1'b1;
         end else if (handshake) begin
            mem_wr_en <= 1'b0;
         end
         // One free slot of slack absorbs the pixel already in flight when enable drops.
         ir_enable  <= (state_next == S_RUN) && (count_next <= (PTR_W+1)'(FIFO_DEPTH-2));
         frame_done <= (state_next == S_DONE);
         if ((state == S_IDLE) && ir_kick)
            pix_count <= '0;
         else if (handshake)
            pix_count <= pix_count + 1'b1;
         if (overflow)
            err_overflow <= 1'b1;
         if (protocol_err)
            err_protocol <= 1'b1;
      end
   end
endmodule
